// File: rtl/maj67_top.sv
// 67-input majority voter: a full-adder popcount tree feeds a threshold compare.
// The compare result is registered once, giving one cycle of latency to y0.
module maj67_top (
  input  logic clk,
  input  logic rst_n,
  input  logic x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,  x8,  x9,
  input  logic x10, x11, x12, x13, x14, x15, x16, x17, x18, x19,
  input  logic x20, x21, x22, x23, x24, x25, x26, x27, x28, x29,
  input  logic x30, x31, x32, x33, x34, x35, x36, x37, x38, x39,
  input  logic x40, x41, x42, x43, x44, x45, x46, x47, x48, x49,
  input  logic x50, x51, x52, x53, x54, x55, x56, x57, x58, x59,
  input  logic x60, x61, x62, x63, x64, x65, x66,
  output logic y0
);

  localparam int unsigned N      = 67;
  localparam int unsigned Thresh = 34;
  localparam int unsigned Cw     = 7;

  logic [N-1:0]  x;
  logic [1:0]    s1 [22];
  logic [2:0]    s2 [11];
  logic [3:0]    s3 [5];
  logic [4:0]    s4 [3];
  logic [5:0]    s5;
  logic [Cw-1:0] cnt;
  logic          maj;
  logic          y0_q;

  assign x = {x66, x65, x64, x63, x62, x61, x60,
              x59, x58, x57, x56, x55, x54, x53, x52, x51, x50,
              x49, x48, x47, x46, x45, x44, x43, x42, x41, x40,
              x39, x38, x37, x36, x35, x34, x33, x32, x31, x30,
              x29, x28, x27, x26, x25, x24, x23, x22, x21, x20,
              x19, x18, x17, x16, x15, x14, x13, x12, x11, x10,
              x9,  x8,  x7,  x6,  x5,  x4,  x3,  x2,  x1,  x0};

  // First level: 22 full adders compress x0..x65 into 2-bit counts; x66 joins at the end.
  for (genvar i = 0; i < 22; i++) begin : g_fa
    logic a, b, c;
    assign a = x[3*i];
    assign b = x[3*i+1];
    assign c = x[3*i+2];
    assign s1[i] = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  end

  for (genvar i = 0; i < 11; i++) begin : g_l2
    assign s2[i] = {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
  end

  for (genvar i = 0; i < 5; i++) begin : g_l3
    assign s3[i] = {1'b0, s2[2*i]} + {1'b0, s2[2*i+1]};
  end

  assign s4[0] = {1'b0, s3[0]} + {1'b0, s3[1]};
  assign s4[1] = {1'b0, s3[2]} + {1'b0, s3[3]};
  assign s4[2] = {1'b0, s3[4]} + {2'b0, s2[10]};
  assign s5    = {1'b0, s4[0]} + {1'b0, s4[1]};

  // Peak value is 48 + 18 + 1 = 67, so 7 bits never overflow.
  assign cnt = {1'b0, s5} + {2'b0, s4[2]} + {6'b0, x[66]};
  assign maj = (cnt >= Cw'(Thresh));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_q <= 1'b0;
    end else begin
      y0_q <= maj;
    end
  end

  assign y0 = y0_q;

endmodule

// File: tb/tb_maj67_top.sv
// Bench for maj67_top: directed threshold/extreme/reset cases plus random and
// popcount-biased vectors, checked every cycle against a one-cycle-delayed vote model.
module tb_maj67_top;

  logic        clk;
  logic        rst_n;
  logic [66:0] xv;
  logic        y0;

  int checks;
  int errors;

  // Model state: expected y0 plus the vector that produced it.
  logic        exp_y;
  logic [66:0] prev_x;
  int          prev_cnt;

  maj67_top dut (
    .clk(clk), .rst_n(rst_n),
    .x0(xv[0]),   .x1(xv[1]),   .x2(xv[2]),   .x3(xv[3]),   .x4(xv[4]),
    .x5(xv[5]),   .x6(xv[6]),   .x7(xv[7]),   .x8(xv[8]),   .x9(xv[9]),
    .x10(xv[10]), .x11(xv[11]), .x12(xv[12]), .x13(xv[13]), .x14(xv[14]),
    .x15(xv[15]), .x16(xv[16]), .x17(xv[17]), .x18(xv[18]), .x19(xv[19]),
    .x20(xv[20]), .x21(xv[21]), .x22(xv[22]), .x23(xv[23]), .x24(xv[24]),
    .x25(xv[25]), .x26(xv[26]), .x27(xv[27]), .x28(xv[28]), .x29(xv[29]),
    .x30(xv[30]), .x31(xv[31]), .x32(xv[32]), .x33(xv[33]), .x34(xv[34]),
    .x35(xv[35]), .x36(xv[36]), .x37(xv[37]), .x38(xv[38]), .x39(xv[39]),
    .x40(xv[40]), .x41(xv[41]), .x42(xv[42]), .x43(xv[43]), .x44(xv[44]),
    .x45(xv[45]), .x46(xv[46]), .x47(xv[47]), .x48(xv[48]), .x49(xv[49]),
    .x50(xv[50]), .x51(xv[51]), .x52(xv[52]), .x53(xv[53]), .x54(xv[54]),
    .x55(xv[55]), .x56(xv[56]), .x57(xv[57]), .x58(xv[58]), .x59(xv[59]),
    .x60(xv[60]), .x61(xv[61]), .x62(xv[62]), .x63(xv[63]), .x64(xv[64]),
    .x65(xv[65]), .x66(xv[66]),
    .y0(y0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int popcnt(input logic [66:0] v);
    int n = 0;
    for (int i = 0; i < 67; i++) n += int'(v[i]);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_y    <= 1'b0;
      prev_x   <= '0;
      prev_cnt <= 0;
    end else begin
      exp_y    <= (popcnt(xv) >= 34);
      prev_x   <= xv;
      prev_cnt <= popcnt(xv);
    end
  end

  task automatic check(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: y0=%b expected=%b", name, got, want);
    end
  endtask

  // Advance to the next falling edge and compare y0 against the model.
  task automatic tick();
    @(negedge clk);
    checks++;
    if (y0 !== exp_y) begin
      errors++;
      $display("FAIL model t=%0t x=%h popcount=%0d y0=%b ref=%b",
               $time, prev_x, prev_cnt, y0, exp_y);
    end
  endtask

  function automatic logic [66:0] biased(input int k);
    logic [66:0] v = '0;
    while (popcnt(v) < k) v[$urandom_range(66, 0)] = 1'b1;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: y0=%b expected=finish", y0);
    $fatal(1, "timeout");
  end

  initial begin
    logic [66:0] v;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    xv     = '1;

    // Reset holds y0 low even with every input voting 1.
    repeat (3) begin
      tick();
      check("reset_hold", y0, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    check("reset_release", y0, 1'b1);

    xv = '0;
    for (int i = 0; i < 33; i++) xv[i] = 1'b1;
    tick();
    check("cnt33", y0, 1'b0);
    xv[33] = 1'b1;
    tick();
    check("cnt34", y0, 1'b1);

    xv = '0;
    tick();
    check("all_zero", y0, 1'b0);
    xv = '1;
    tick();
    check("all_one", y0, 1'b1);
    for (int i = 0; i < 67; i++) xv[i] = (i % 2 == 1);
    tick();
    check("alternating33", y0, 1'b0);

    xv = '0;
    for (int i = 33; i < 67; i++) xv[i] = 1'b1;
    tick();
    check("high34", y0, 1'b1);
    xv[66] = 1'b0;
    tick();
    check("high33", y0, 1'b0);

    // Asynchronous reset between edges.
    xv = '1;
    tick();
    check("async_pre", y0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", y0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("async_release", y0, 1'b1);

    for (int n = 0; n < 20000; n++) begin
      v = {$urandom(), $urandom(), $urandom()};
      xv = v[66:0];
      tick();
    end

    for (int n = 0; n < 4000; n++) begin
      xv = biased($urandom_range(35, 32));
      tick();
    end

    // Reset in the middle of traffic discards the pending vote.
    xv = biased(40);
    #1 rst_n = 1'b0;
    tick();
    check("mid_reset", y0, 1'b0);
    xv = biased(20);
    rst_n = 1'b1;
    tick();
    check("mid_release", y0, 1'b0);
    for (int n = 0; n < 200; n++) begin
      xv = biased($urandom_range(36, 31));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
